register_file_v2: RTL and testbench
===================================

// Module: register_file_v2
// PURPOSE
//   Parametrised 2-read/1-write CPU register file, next generation of the v1 file.
//   Adds: async active-low reset; synchronised and edge-captured I/O registers;
//   optional write-to-read bypass; per-register pending scoreboard for multicycle writeback.
//   Sits between decode (read addresses, pending set) and writeback (write port) in the CPU core.
// PARAMETERS
//   BUS_WIDTH   8  data width of every register and port
//   ADDR_WIDTH  3  register address width; N = 2**ADDR_WIDTH registers; must be >= 3
//   SYNC_STAGES 2  flop stages on sw / ready_in / pattern_match inputs; must be >= 2
//   BYPASS      1  1: same-cycle write data forwarded to read ports; 0: read old contents
// PORTS
//   clock          in   1           system clock, all state on rising edge
//   nreset         in   1           asynchronous active-low reset
//   sw             in   BUS_WIDTH   switch inputs, asynchronous to clock
//   ready_in       in   1           external ready level, asynchronous
//   pattern_match  in   1           pattern detector flag, asynchronous
//   we             in   1           write enable
//   wr_addr        in   ADDR_WIDTH  write address
//   wr_data        in   BUS_WIDTH   write data
//   rd_addr_a      in   ADDR_WIDTH  read port A address
//   rd_addr_b      in   ADDR_WIDTH  read port B address
//   rd_ack_a       in   1           port A read consumed; clears sticky ready when rd_addr_a==2
//   pend_set       in   1           mark register pend_addr pending (multicycle op issued)
//   pend_addr      in   ADDR_WIDTH  register to mark pending
//   rd_data_a      out  BUS_WIDTH   read port A data (combinational)
//   rd_data_b      out  BUS_WIDTH   read port B data (combinational)
//   busy_a         out  1           rd_addr_a register pending, data not valid
//   busy_b         out  1           rd_addr_b register pending, data not valid
// BEHAVIOUR
//   Reset: nreset low -> all GPRs, sync flops, sticky ready, pending bits = 0 immediately;
//     hence rd_data_* = 0 for GPR/sticky addresses, busy_* = 0. Reset mid-write discards the write.
//   Address map: 0 = constant zero; 1 = sw_s (sw after SYNC_STAGES flops); 2 = {0.., rdy_sticky};
//     3 = {0.., pm_s} (synchronised pattern_match); 4..N-1 = GPRs.
//   Writes to addresses 0..3 ignored (no state change, no pending clear).
//   Write: we=1, wr_addr>=4 -> gpr[wr_addr] <= wr_data at clock edge; visible next cycle.
//   Reads: combinational, zero latency. BYPASS=1 and we=1 and wr_addr==rd_addr_x>=4
//     -> rd_data_x = wr_data same cycle; BYPASS=0 -> old contents. Both ports independent.
//   Input latency: sw/pattern_match change visible at addr 1/3 exactly SYNC_STAGES edges later.
//   Sticky ready: rdy_s = synchronised ready_in; rising edge of rdy_s (rdy_s & ~rdy_s_q) sets
//     rdy_sticky at next edge; cleared at edge when rd_ack_a=1 and rd_addr_a==2.
//     Set and clear same cycle -> set wins (flag stays 1). Level held high sets only once.
//   Scoreboard pend[N-1:0]: pend_set=1, pend_addr>=4 -> pend[pend_addr] <= 1.
//     we=1, wr_addr>=4 -> pend[wr_addr] <= 0. Same address set+clear same cycle -> set wins
//     (new op issued after old writeback). pend_addr<4 ignored; pend[0..3] always 0.
//   busy_x = pend[rd_addr_x] & ~(BYPASS & we & wr_addr==rd_addr_x) -- bypassed writeback
//     resolves the hazard in the same cycle; BYPASS=0 -> busy_x = pend[rd_addr_x].
//   All arithmetic unsigned; constant-register zero-extension fills upper BUS_WIDTH-1 bits with 0.
// TESTING
//   1 Reset: drive writes/pend_set, pulse nreset low mid-cycle -> all reads 0, busy 0 asynchronously.
//   2 Write gpr[5]=8'hA5, read A=5,B=5 next cycle -> both 8'hA5; write addr 0/2 -> reads 0/unchanged.
//   3 BYPASS=1: we, wr_addr=4, wr_data=8'h3C, rd_addr_a=4 same cycle -> rd_data_a=8'h3C;
//     BYPASS=0 build -> old value until next cycle.
//   4 sw 8'h00->8'h81 -> addr 1 reads 8'h81 exactly 2 edges later (SYNC_STAGES=2), not before.
//   5 ready_in pulse high 3 cycles -> addr 2 reads 1 after sync, stays 1 after pulse ends;
//     rd_ack_a with rd_addr_a=2 -> 0; new edge coincident with ack -> stays 1.
//   6 pend_set addr 6 -> busy_a=1 for rd_addr_a=6; write addr 6 -> busy_a=0 that cycle
//     (BYPASS=1) / next cycle (BYPASS=0); pend_set+we both addr 6 -> remains pending.

Source files
------------

// File: rtl/register_file_v2.sv
// register_file_v2: 2-read/1-write register file with synchronised I/O registers, optional bypass and pending scoreboard
module register_file_v2 #(
  parameter int BUS_WIDTH   = 8,
  parameter int ADDR_WIDTH  = 3,
  parameter int SYNC_STAGES = 2,
  parameter bit BYPASS      = 1'b1
) (
  input  logic                  clock,
  input  logic                  nreset,
  input  logic [BUS_WIDTH-1:0]  sw,
  input  logic                  ready_in,
  input  logic                  pattern_match,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [BUS_WIDTH-1:0]  wr_data,
  input  logic [ADDR_WIDTH-1:0] rd_addr_a,
  input  logic [ADDR_WIDTH-1:0] rd_addr_b,
  input  logic                  rd_ack_a,
  input  logic                  pend_set,
  input  logic [ADDR_WIDTH-1:0] pend_addr,
  output logic [BUS_WIDTH-1:0]  rd_data_a,
  output logic [BUS_WIDTH-1:0]  rd_data_b,
  output logic                  busy_a,
  output logic                  busy_b
);
  localparam int N = 2 ** ADDR_WIDTH;
  localparam logic [ADDR_WIDTH-1:0] A_SW  = ADDR_WIDTH'(1);
  localparam logic [ADDR_WIDTH-1:0] A_RDY = ADDR_WIDTH'(2);
  localparam logic [ADDR_WIDTH-1:0] A_PM  = ADDR_WIDTH'(3);
  localparam logic [ADDR_WIDTH-1:0] A_GPR = ADDR_WIDTH'(4);

  logic [BUS_WIDTH-1:0]   gpr [N];
  logic [BUS_WIDTH-1:0]   sw_q [SYNC_STAGES];
  logic [SYNC_STAGES-1:0] rdy_q, pm_q;
  logic                   rdy_s_q, rdy_sticky, rdy_rise, wr_ok;
  logic [N-1:0]           pend;

  assign wr_ok    = we && wr_addr >= A_GPR;
  assign rdy_rise = rdy_q[SYNC_STAGES-1] & ~rdy_s_q;

  always_ff @(posedge clock or negedge nreset) begin
    if (!nreset) begin
      for (int i = 0; i < N; i++) gpr[i] <= '0;
      for (int i = 0; i < SYNC_STAGES; i++) sw_q[i] <= '0;
      rdy_q      <= '0;
      pm_q       <= '0;
      rdy_s_q    <= 1'b0;
      rdy_sticky <= 1'b0;
      pend       <= '0;
    end else begin
      if (wr_ok) gpr[wr_addr] <= wr_data;
      sw_q[0] <= sw;
      for (int i = 1; i < SYNC_STAGES; i++) sw_q[i] <= sw_q[i-1];
      rdy_q   <= {rdy_q[SYNC_STAGES-2:0], ready_in};
      pm_q    <= {pm_q[SYNC_STAGES-2:0], pattern_match};
      rdy_s_q <= rdy_q[SYNC_STAGES-1];
      // a new ready edge outranks a simultaneous acknowledge
      if (rdy_rise) rdy_sticky <= 1'b1;
      else if (rd_ack_a && rd_addr_a == A_RDY) rdy_sticky <= 1'b0;
      // issuing a new op outranks the writeback of the previous one
      for (int i = 4; i < N; i++)
        if (pend_set && pend_addr == ADDR_WIDTH'(i)) pend[i] <= 1'b1;
        else if (wr_ok && wr_addr == ADDR_WIDTH'(i)) pend[i] <= 1'b0;
    end
  end

  function automatic logic byp(input logic [ADDR_WIDTH-1:0] a);
    return BYPASS && wr_ok && wr_addr == a;
  endfunction

  function automatic logic [BUS_WIDTH-1:0] rd(input logic [ADDR_WIDTH-1:0] a);
    return byp(a)     ? wr_data :
           a == A_SW  ? sw_q[SYNC_STAGES-1] :
           a == A_RDY ? BUS_WIDTH'(rdy_sticky) :
           a == A_PM  ? BUS_WIDTH'(pm_q[SYNC_STAGES-1]) :
           a >= A_GPR ? gpr[a] : '0;
  endfunction

  always_comb begin
    rd_data_a = rd(rd_addr_a);
    rd_data_b = rd(rd_addr_b);
    busy_a    = pend[rd_addr_a] & ~byp(rd_addr_a);
    busy_b    = pend[rd_addr_b] & ~byp(rd_addr_b);
  end
endmodule

// File: tb/tb_register_file_v2.sv
// tb_register_file_v2: directed checks of a bypassing and a non-bypassing register_file_v2 sharing one stimulus
module tb_register_file_v2;
  logic       clock = 1'b0, nreset = 1'b0;
  logic [7:0] sw = '0, wr_data = '0;
  logic       ready_in = 1'b0, pattern_match = 1'b0, we = 1'b0, rd_ack_a = 1'b0, pend_set = 1'b0;
  logic [2:0] wr_addr = '0, rd_addr_a = '0, rd_addr_b = '0, pend_addr = '0;
  logic [7:0] da, db, na, nb;
  logic       ba, bb, nba, nbb;
  int checks = 0, failures = 0;

  always #5 clock = ~clock;

  register_file_v2 dut (
    .clock(clock), .nreset(nreset), .sw(sw), .ready_in(ready_in), .pattern_match(pattern_match),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_ack_a(rd_ack_a), .pend_set(pend_set), .pend_addr(pend_addr),
    .rd_data_a(da), .rd_data_b(db), .busy_a(ba), .busy_b(bb));

  register_file_v2 #(.BYPASS(1'b0)) dut_nb (
    .clock(clock), .nreset(nreset), .sw(sw), .ready_in(ready_in), .pattern_match(pattern_match),
    .we(we), .wr_addr(wr_addr), .wr_data(wr_data), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_ack_a(rd_ack_a), .pend_set(pend_set), .pend_addr(pend_addr),
    .rd_data_a(na), .rd_data_b(nb), .busy_a(nba), .busy_b(nbb));

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic test_reset();
    nreset = 1'b1;
    we = 1'b1; wr_addr = 3'd5; wr_data = 8'hFF;
    pend_set = 1'b1; pend_addr = 3'd6;
    step();
    we = 1'b0; pend_set = 1'b0; rd_addr_a = 3'd5; rd_addr_b = 3'd6;
    #1;
    checks++; if (da !== 8'hFF) begin failures++; $display("FAIL pre_reset_data got=%h exp=ff", da); end
    checks++; if (bb !== 1'b1) begin failures++; $display("FAIL pre_reset_busy got=%b exp=1", bb); end
    we = 1'b1; wr_addr = 3'd7; wr_data = 8'h77;
    #1 nreset = 1'b0;
    #1;
    we = 1'b0;
    #1;
    checks++; if (da !== 8'h00 || na !== 8'h00) begin failures++; $display("FAIL reset_data got=%h/%h exp=00", da, na); end
    checks++; if (bb !== 1'b0 || nbb !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b/%b exp=0", bb, nbb); end
    #1 nreset = 1'b1;
    step();
    rd_addr_a = 3'd7;
    #1;
    checks++; if (da !== 8'h00) begin failures++; $display("FAIL reset_discards_write got=%h exp=00", da); end
  endtask

  task automatic test_write();
    we = 1'b1; wr_addr = 3'd5; wr_data = 8'hA5; rd_addr_a = 3'd5; rd_addr_b = 3'd5;
    #1;
    checks++; if (na !== 8'h00) begin failures++; $display("FAIL nobypass_old got=%h exp=00", na); end
    step();
    we = 1'b0;
    #1;
    checks++; if (da !== 8'hA5 || db !== 8'hA5) begin failures++; $display("FAIL write_read got=%h/%h exp=a5", da, db); end
    checks++; if (na !== 8'hA5 || nb !== 8'hA5) begin failures++; $display("FAIL nb_write_read got=%h/%h exp=a5", na, nb); end
    we = 1'b1; wr_addr = 3'd0; wr_data = 8'h55; rd_addr_a = 3'd0; rd_addr_b = 3'd2;
    #1;
    checks++; if (da !== 8'h00 || db !== 8'h00) begin failures++; $display("FAIL write_low_bypass got=%h/%h exp=00", da, db); end
    step();
    wr_addr = 3'd2;
    step();
    we = 1'b0;
    #1;
    checks++; if (da !== 8'h00 || db !== 8'h00) begin failures++; $display("FAIL write_low_ignored got=%h/%h exp=00", da, db); end
  endtask

  task automatic test_bypass();
    we = 1'b1; wr_addr = 3'd4; wr_data = 8'h3C; rd_addr_a = 3'd4; rd_addr_b = 3'd5;
    #1;
    checks++; if (da !== 8'h3C) begin failures++; $display("FAIL bypass got=%h exp=3c", da); end
    checks++; if (na !== 8'h00) begin failures++; $display("FAIL nobypass got=%h exp=00", na); end
    checks++; if (db !== 8'hA5) begin failures++; $display("FAIL bypass_other_port got=%h exp=a5", db); end
    step();
    we = 1'b0;
    #1;
    checks++; if (na !== 8'h3C || da !== 8'h3C) begin failures++; $display("FAIL after_write got=%h/%h exp=3c", da, na); end
  endtask

  task automatic test_sync();
    sw = 8'h81; pattern_match = 1'b1; rd_addr_a = 3'd1; rd_addr_b = 3'd3;
    #1;
    checks++; if (da !== 8'h00 || db !== 8'h00) begin failures++; $display("FAIL sync_edge0 got=%h/%h exp=00/00", da, db); end
    step();
    checks++; if (da !== 8'h00 || db !== 8'h00) begin failures++; $display("FAIL sync_edge1 got=%h/%h exp=00/00", da, db); end
    step();
    checks++; if (da !== 8'h81 || db !== 8'h01) begin failures++; $display("FAIL sync_edge2 got=%h/%h exp=81/01", da, db); end
  endtask

  task automatic test_ready();
    ready_in = 1'b1; rd_addr_a = 3'd2;
    step();
    step();
    checks++; if (da !== 8'h00) begin failures++; $display("FAIL ready_early got=%h exp=00", da); end
    step();
    ready_in = 1'b0;
    #1;
    checks++; if (da !== 8'h01) begin failures++; $display("FAIL ready_set got=%h exp=01", da); end
    step();
    step();
    checks++; if (da !== 8'h01) begin failures++; $display("FAIL ready_sticky got=%h exp=01", da); end
    rd_ack_a = 1'b1;
    step();
    rd_ack_a = 1'b0; ready_in = 1'b1;
    #1;
    checks++; if (da !== 8'h00) begin failures++; $display("FAIL ready_ack got=%h exp=00", da); end
    step();
    step();
    rd_ack_a = 1'b1;
    step();
    rd_ack_a = 1'b0;
    #1;
    checks++; if (da !== 8'h01) begin failures++; $display("FAIL ready_set_wins got=%h exp=01", da); end
    rd_ack_a = 1'b1;
    step();
    rd_ack_a = 1'b0;
    step();
    step();
    checks++; if (da !== 8'h00) begin failures++; $display("FAIL ready_level_once got=%h exp=00", da); end
    ready_in = 1'b0;
  endtask

  task automatic test_pending();
    rd_addr_a = 3'd6; rd_addr_b = 3'd3;
    pend_set = 1'b1; pend_addr = 3'd6;
    step();
    pend_set = 1'b0;
    #1;
    checks++; if (ba !== 1'b1 || nba !== 1'b1) begin failures++; $display("FAIL pend_set got=%b/%b exp=1/1", ba, nba); end
    we = 1'b1; wr_addr = 3'd6; wr_data = 8'h11;
    #1;
    checks++; if (ba !== 1'b0 || nba !== 1'b1) begin failures++; $display("FAIL pend_wb_same got=%b/%b exp=0/1", ba, nba); end
    step();
    we = 1'b0;
    #1;
    checks++; if (ba !== 1'b0 || nba !== 1'b0) begin failures++; $display("FAIL pend_wb_next got=%b/%b exp=0/0", ba, nba); end
    we = 1'b1; pend_set = 1'b1;
    step();
    we = 1'b0; pend_set = 1'b0;
    #1;
    checks++; if (ba !== 1'b1 || nba !== 1'b1) begin failures++; $display("FAIL pend_set_wins got=%b/%b exp=1/1", ba, nba); end
    checks++; if (da !== 8'h11) begin failures++; $display("FAIL pend_data got=%h exp=11", da); end
    pend_set = 1'b1; pend_addr = 3'd3;
    step();
    pend_set = 1'b0;
    #1;
    checks++; if (bb !== 1'b0) begin failures++; $display("FAIL pend_low_ignored got=%b exp=0", bb); end
  endtask

  initial begin
    #12;
    test_reset();
    test_write();
    test_bypass();
    test_sync();
    test_ready();
    test_pending();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
